// File: rtl/tx_chunk_serializer_if.sv
// Chunk-in / UART-out signal bundle for the TX chunk serializer.
// The master side is the upstream detector plus UART; the slave side is the serializer.
interface tx_chunk_serializer_if #(
    parameter int TEXT_BUFFER_BYTE_SIZE  = 33,
    parameter int TEXT_BUFFER_INDEX_SIZE = 8
);
    logic                                     should_update;
    logic [7:0]                               tx_chunk_type;
    logic [TEXT_BUFFER_INDEX_SIZE-1:0]        tx_chunk_size;
    logic [(TEXT_BUFFER_BYTE_SIZE-1)*8-1:0]   tx_chunk_bytes;
    logic                                     chunk_done;
    logic [7:0]                               uart_tx_data;
    logic                                     uart_tx_start;
    logic                                     uart_tx_ready;
    logic                                     busy;

    modport master (
        output should_update, tx_chunk_type, tx_chunk_size, tx_chunk_bytes, uart_tx_ready,
        input  chunk_done, uart_tx_data, uart_tx_start, busy
    );

    modport slave (
        input  should_update, tx_chunk_type, tx_chunk_size, tx_chunk_bytes, uart_tx_ready,
        output chunk_done, uart_tx_data, uart_tx_start, busy
    );
endinterface

// File: rtl/tx_chunk_serializer.sv
// Serialises one latched TX chunk into the UART as [type][size][payload][xor checksum],
// then acknowledges upstream with a single-cycle chunk_done pulse.
module tx_chunk_serializer #(
    parameter int TEXT_BUFFER_BYTE_SIZE  = 33,
    parameter int TEXT_BUFFER_INDEX_SIZE = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    tx_chunk_serializer_if.slave  bus
);
    localparam int PAYLOAD_BYTES = TEXT_BUFFER_BYTE_SIZE - 1;
    localparam int IDX_W         = $clog2(TEXT_BUFFER_BYTE_SIZE + 2);
    localparam int PIDX_W        = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] SEND = 3'd1;
    localparam logic [2:0] HOLD = 3'd2;
    localparam logic [2:0] WAIT = 3'd3;
    localparam logic [2:0] DONE = 3'd4;
    localparam logic [2:0] COOL = 3'd5;

    logic [2:0]       state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [7:0]       chk_reg;
    logic [7:0]       type_reg;
    logic [7:0]       len_reg;
    logic [7:0]       tx_data_reg;
    logic             tx_start_reg;
    logic [7:0]       payload_reg [PAYLOAD_BYTES];

    logic [7:0]        in_bytes [PAYLOAD_BYTES];
    logic [7:0]        size_ext;
    logic [7:0]        n_clamped;
    logic [PIDX_W-1:0] pidx;
    logic              last_idx;
    logic              latch_en;
    logic [7:0]        frame_byte;

    genvar gi;
    generate
        for (gi = 0; gi < PAYLOAD_BYTES; gi++) begin : g_unpack
            assign in_bytes[gi] = bus.tx_chunk_bytes[8*gi +: 8];
        end
    endgenerate

    assign size_ext  = 8'(bus.tx_chunk_size);
    assign n_clamped = (size_ext > 8'(PAYLOAD_BYTES)) ? 8'(PAYLOAD_BYTES) : size_ext;
    assign latch_en  = (state_reg == IDLE) && bus.should_update;
    assign pidx      = PIDX_W'(idx_reg - IDX_W'(2));
    assign last_idx  = (int'(idx_reg) == int'(len_reg) + 2);

    // Frame byte for the current index; the checksum slot carries the running XOR.
    always_comb begin
        frame_byte = chk_reg;
        if (idx_reg == '0)
            frame_byte = type_reg;
        else if (idx_reg == IDX_W'(1))
            frame_byte = len_reg;
        else if (!last_idx)
            frame_byte = payload_reg[pidx];
    end

    // Payload snapshot is pure data, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (latch_en)
            payload_reg <= in_bytes;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            chk_reg      <= '0;
            type_reg     <= '0;
            len_reg      <= '0;
            tx_data_reg  <= '0;
            tx_start_reg <= 1'b0;
        end else begin
            tx_start_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.should_update) begin
                        type_reg  <= bus.tx_chunk_type;
                        len_reg   <= n_clamped;
                        idx_reg   <= '0;
                        chk_reg   <= '0;
                        state_reg <= SEND;
                    end
                end
                SEND: begin
                    if (bus.uart_tx_ready) begin
                        tx_data_reg  <= frame_byte;
                        tx_start_reg <= 1'b1;
                        chk_reg      <= chk_reg ^ frame_byte;
                        state_reg    <= HOLD;
                    end
                end
                // UART ready lags the start by a cycle, so it is not trusted here.
                HOLD: state_reg <= WAIT;
                WAIT: begin
                    if (bus.uart_tx_ready) begin
                        if (last_idx) begin
                            state_reg <= DONE;
                        end else begin
                            idx_reg   <= idx_reg + IDX_W'(1);
                            state_reg <= SEND;
                        end
                    end
                end
                DONE: state_reg <= COOL;
                COOL: begin
                    if (!bus.should_update)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.uart_tx_data  = tx_data_reg;
    assign bus.uart_tx_start = tx_start_reg;
    assign bus.chunk_done    = (state_reg == DONE);
    assign bus.busy          = (state_reg != IDLE);
endmodule
